// File: rtl/reservation_station_pkg.sv
// Shared types and constants for the integer reservation station.
// Consumed by reservation_station and rs_select.
package reservation_station_pkg;

  localparam int OPENUM_W  = 6;
  localparam int ROB_POS_W = 5;
  localparam int DATA_W    = 32;
  localparam int RS_SIZE   = 16;
  localparam int RS_IDX_W  = $clog2(RS_SIZE);

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [OPENUM_W-1:0] {
    OPENUM_NOP,
    OPENUM_LUI,
    OPENUM_AUIPC,
    OPENUM_JAL,
    OPENUM_JALR,
    OPENUM_BEQ,
    OPENUM_BNE,
    OPENUM_BLT,
    OPENUM_BGE,
    OPENUM_BLTU,
    OPENUM_BGEU,
    OPENUM_ADDI,
    OPENUM_SLTI,
    OPENUM_SLTIU,
    OPENUM_XORI,
    OPENUM_ORI,
    OPENUM_ANDI,
    OPENUM_SLLI,
    OPENUM_SRLI,
    OPENUM_SRAI,
    OPENUM_ADD,
    OPENUM_SUB,
    OPENUM_SLL,
    OPENUM_SLT,
    OPENUM_SLTU,
    OPENUM_XOR,
    OPENUM_SRL,
    OPENUM_SRA,
    OPENUM_OR,
    OPENUM_AND
  } openum_e;

endpackage

// File: rtl/reservation_station_rs_select.sv
// Priority encoders for the reservation station: lowest free slot
// and lowest issue-ready slot.
module rs_select
  import reservation_station_pkg::*;
#(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     busy,
  input  logic [N-1:0]     ready,
  output logic [IDX_W-1:0] free_idx,
  output logic             free_found,
  output logic [IDX_W-1:0] sel_idx,
  output logic             sel_found
);

  // scan high-to-low so the lowest matching index wins
  always_comb begin
    free_idx   = '0;
    free_found = FALSE;
    sel_idx    = '0;
    sel_found  = FALSE;
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_idx   = IDX_W'(i);
        free_found = TRUE;
      end
      if (ready[i]) begin
        sel_idx   = IDX_W'(i);
        sel_found = TRUE;
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Out-of-order issue buffer feeding the ALU, one issue per cycle.
// Define RS_WAKEUP_BYPASS_EN to let a broadcast wake and issue in one cycle.
module reservation_station
  import reservation_station_pkg::DATA_W;
#(
  parameter int RS_SIZE   = 16,
  parameter int ROB_POS_W = 5,
  parameter int OPENUM_W  = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy,
  input  logic                 clr,
  input  logic                 dis_enable,
  input  logic [OPENUM_W-1:0]  dis_openum,
  input  logic [ROB_POS_W-1:0] dis_rob_pos,
  input  logic [DATA_W-1:0]    dis_rs1_val,
  input  logic [DATA_W-1:0]    dis_rs2_val,
  input  logic                 dis_rs1_rdy,
  input  logic                 dis_rs2_rdy,
  input  logic [ROB_POS_W-1:0] dis_rs1_dep,
  input  logic [ROB_POS_W-1:0] dis_rs2_dep,
  input  logic [DATA_W-1:0]    dis_imm,
  input  logic [DATA_W-1:0]    dis_pc,
  output logic                 rs_full,
  input  logic                 alu_bc_enable,
  input  logic [ROB_POS_W-1:0] alu_bc_rob_pos,
  input  logic [DATA_W-1:0]    alu_bc_val,
  input  logic                 lsb_bc_enable,
  input  logic [ROB_POS_W-1:0] lsb_bc_rob_pos,
  input  logic [DATA_W-1:0]    lsb_bc_val,
  output logic                 rs_to_alu_enable,
  output logic [OPENUM_W-1:0]  rs_to_alu_openum,
  output logic [ROB_POS_W-1:0] rs_to_alu_rob_pos,
  output logic [DATA_W-1:0]    rs_to_alu_rs1_val,
  output logic [DATA_W-1:0]    rs_to_alu_rs2_val,
  output logic [DATA_W-1:0]    rs_to_alu_imm,
  output logic [DATA_W-1:0]    rs_to_alu_pc
);

  import reservation_station_pkg::TRUE;
  import reservation_station_pkg::FALSE;

  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0]   busy;
  logic [RS_SIZE-1:0]   qj_v;
  logic [RS_SIZE-1:0]   qk_v;
  logic [OPENUM_W-1:0]  op_q  [RS_SIZE];
  logic [ROB_POS_W-1:0] rob_q [RS_SIZE];
  logic [DATA_W-1:0]    vj    [RS_SIZE];
  logic [DATA_W-1:0]    vk    [RS_SIZE];
  logic [ROB_POS_W-1:0] qj    [RS_SIZE];
  logic [ROB_POS_W-1:0] qk    [RS_SIZE];
  logic [DATA_W-1:0]    imm_q [RS_SIZE];
  logic [DATA_W-1:0]    pc_q  [RS_SIZE];

  logic [DATA_W-1:0]  vj_n [RS_SIZE];
  logic [DATA_W-1:0]  vk_n [RS_SIZE];
  logic [RS_SIZE-1:0] qjv_n;
  logic [RS_SIZE-1:0] qkv_n;
  logic [RS_SIZE-1:0] ready;

  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             free_found;
  logic             sel_found;

  logic [DATA_W-1:0] dis_vj;
  logic [DATA_W-1:0] dis_vk;
  logic              dis_qjv;
  logic              dis_qkv;

  // per-entry operand view after this cycle's broadcasts (ALU wins ties)
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      vj_n[i]  = vj[i];
      qjv_n[i] = qj_v[i];
      vk_n[i]  = vk[i];
      qkv_n[i] = qk_v[i];
      if (qj_v[i] && alu_bc_enable && alu_bc_rob_pos == qj[i]) begin
        vj_n[i]  = alu_bc_val;
        qjv_n[i] = FALSE;
      end else if (qj_v[i] && lsb_bc_enable && lsb_bc_rob_pos == qj[i]) begin
        vj_n[i]  = lsb_bc_val;
        qjv_n[i] = FALSE;
      end
      if (qk_v[i] && alu_bc_enable && alu_bc_rob_pos == qk[i]) begin
        vk_n[i]  = alu_bc_val;
        qkv_n[i] = FALSE;
      end else if (qk_v[i] && lsb_bc_enable && lsb_bc_rob_pos == qk[i]) begin
        vk_n[i]  = lsb_bc_val;
        qkv_n[i] = FALSE;
      end
`ifdef RS_WAKEUP_BYPASS_EN
      ready[i] = busy[i] && !qjv_n[i] && !qkv_n[i];
`else
      ready[i] = busy[i] && !qj_v[i] && !qk_v[i];
`endif
    end
  end

  // operands arriving on a broadcast in the dispatch cycle are captured
  always_comb begin
    dis_vj  = dis_rs1_val;
    dis_qjv = !dis_rs1_rdy;
    dis_vk  = dis_rs2_val;
    dis_qkv = !dis_rs2_rdy;
    unique case (1'b1)
      dis_rs1_rdy: ;
      alu_bc_enable && alu_bc_rob_pos == dis_rs1_dep: begin
        dis_vj  = alu_bc_val;
        dis_qjv = FALSE;
      end
      lsb_bc_enable && lsb_bc_rob_pos == dis_rs1_dep: begin
        dis_vj  = lsb_bc_val;
        dis_qjv = FALSE;
      end
      default: ;
    endcase
    unique case (1'b1)
      dis_rs2_rdy: ;
      alu_bc_enable && alu_bc_rob_pos == dis_rs2_dep: begin
        dis_vk  = alu_bc_val;
        dis_qkv = FALSE;
      end
      lsb_bc_enable && lsb_bc_rob_pos == dis_rs2_dep: begin
        dis_vk  = lsb_bc_val;
        dis_qkv = FALSE;
      end
      default: ;
    endcase
  end

  rs_select #(
    .N     (RS_SIZE),
    .IDX_W (IDX_W)
  ) u_select (
    .busy       (busy),
    .ready      (ready),
    .free_idx   (free_idx),
    .free_found (free_found),
    .sel_idx    (sel_idx),
    .sel_found  (sel_found)
  );

  assign rs_full = !free_found;

  // entry storage, wakeup, issue and dispatch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      qj_v <= '0;
      qk_v <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op_q[i]  <= '0;
        rob_q[i] <= '0;
        vj[i]    <= '0;
        vk[i]    <= '0;
        qj[i]    <= '0;
        qk[i]    <= '0;
        imm_q[i] <= '0;
        pc_q[i]  <= '0;
      end
      rs_to_alu_enable  <= FALSE;
      rs_to_alu_openum  <= '0;
      rs_to_alu_rob_pos <= '0;
      rs_to_alu_rs1_val <= '0;
      rs_to_alu_rs2_val <= '0;
      rs_to_alu_imm     <= '0;
      rs_to_alu_pc      <= '0;
    end else if (rdy) begin
      if (clr) begin
        busy             <= '0;
        rs_to_alu_enable <= FALSE;
      end else begin
        qj_v <= qjv_n;
        qk_v <= qkv_n;
        for (int i = 0; i < RS_SIZE; i++) begin
          vj[i] <= vj_n[i];
          vk[i] <= vk_n[i];
        end
        if (sel_found) begin
          rs_to_alu_enable  <= TRUE;
          rs_to_alu_openum  <= op_q[sel_idx];
          rs_to_alu_rob_pos <= rob_q[sel_idx];
          rs_to_alu_rs1_val <= vj_n[sel_idx];
          rs_to_alu_rs2_val <= vk_n[sel_idx];
          rs_to_alu_imm     <= imm_q[sel_idx];
          rs_to_alu_pc      <= pc_q[sel_idx];
          busy[sel_idx]     <= FALSE;
        end else begin
          rs_to_alu_enable <= FALSE;
        end
        if (dis_enable && free_found) begin
          busy[free_idx]  <= TRUE;
          op_q[free_idx]  <= dis_openum;
          rob_q[free_idx] <= dis_rob_pos;
          vj[free_idx]    <= dis_vj;
          vk[free_idx]    <= dis_vk;
          qj_v[free_idx]  <= dis_qjv;
          qk_v[free_idx]  <= dis_qkv;
          qj[free_idx]    <= dis_rs1_dep;
          qk[free_idx]    <= dis_rs2_dep;
          imm_q[free_idx] <= dis_imm;
          pc_q[free_idx]  <= dis_pc;
        end
      end
    end
  end

  // the dispatcher must never push into a full station
  dis_when_full: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(rdy && !clr && dis_enable && rs_full)
  );

endmodule
